// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-mode selection stage and the light sequencer:
// mode codes, lamp encodings and the sequencer state enum.
package traffic_pkg;

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        EW_G,
        EW_Y,
        ALLRED,
        PED_WALK,
        NIGHT_FLASH,
        EMG_HOLD
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero flag drives phase expiry
// and the night-flash blink cadence.
module phase_timer #(
    parameter int CNT_W = 4,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Timed Moore sequencer turning the registered traffic mode into NS/EW lamp
// drives; every mode change is routed through yellow and all-red.
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 1,
    parameter int WALK_CYCLES   = 6,
    parameter int BLINK_CYCLES  = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] currentState,
    output logic [2:0] nsLight,
    output logic [2:0] ewLight,
    output logic       walk,
    output logic       emgClear
);

    state_t state, state_next;
    logic   phase_zero, phase_load;
    logic   blink_zero, blink_load, night_entry;
    logic   dir, ped_served, blink;

    function automatic logic [CNT_W-1:0] phase_len_m1(input state_t s);
        case (s)
            NS_G, EW_G: return CNT_W'(GREEN_CYCLES - 1);
            NS_Y, EW_Y: return CNT_W'(YELLOW_CYCLES - 1);
            ALLRED:     return CNT_W'(ALLRED_CYCLES - 1);
            PED_WALK:   return CNT_W'(WALK_CYCLES - 1);
            default:    return '0;
        endcase
    endfunction

    // Counter reloads exactly when the state changes, so each timed state
    // lasts its full duration and nothing restarts a phase mid-way.
    assign phase_load  = (state_next != state);
    assign night_entry = (state_next == NIGHT_FLASH) && (state != NIGHT_FLASH);
    assign blink_load  = night_entry || ((state == NIGHT_FLASH) && blink_zero);

    phase_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (CNT_W'(ALLRED_CYCLES - 1))
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (phase_load),
        .load_value (phase_len_m1(state_next)),
        .zero       (phase_zero)
    );

    phase_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE ('0)
    ) u_blink_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (blink_load),
        .load_value (CNT_W'(BLINK_CYCLES - 1)),
        .zero       (blink_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ALLRED;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir        <= 1'b0;
            ped_served <= 1'b0;
            blink      <= 1'b0;
        end else begin
            if (state_next == NS_Y && state != NS_Y) begin
                dir <= 1'b1;
            end else if (state_next == EW_Y && state != EW_Y) begin
                dir <= 1'b0;
            end

            if (currentState != MODE_PED) begin
                ped_served <= 1'b0;
            end else if (state == PED_WALK && phase_zero) begin
                ped_served <= 1'b1;
            end

            if (night_entry) begin
                blink <= 1'b1;
            end else if (state == NIGHT_FLASH && blink_zero) begin
                blink <= ~blink;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            NS_G: if (phase_zero || currentState == MODE_EMG) state_next = NS_Y;
            EW_G: if (phase_zero || currentState == MODE_EMG) state_next = EW_Y;
            NS_Y, EW_Y, PED_WALK: if (phase_zero) state_next = ALLRED;
            ALLRED: begin
                if (phase_zero) begin
                    if (currentState == MODE_EMG) begin
                        state_next = EMG_HOLD;
                    end else if (currentState == MODE_NIGHT) begin
                        state_next = NIGHT_FLASH;
                    end else if (currentState == MODE_PED && !ped_served) begin
                        state_next = PED_WALK;
                    end else begin
                        state_next = dir ? EW_G : NS_G;
                    end
                end
            end
            NIGHT_FLASH: if (currentState != MODE_NIGHT) state_next = ALLRED;
            EMG_HOLD:    if (currentState != MODE_EMG) state_next = ALLRED;
            default:     state_next = ALLRED;
        endcase
    end

    always_comb begin
        nsLight  = LAMP_RED;
        ewLight  = LAMP_RED;
        walk     = 1'b0;
        emgClear = 1'b0;
        case (state)
            NS_G: nsLight = LAMP_GRN;
            NS_Y: nsLight = LAMP_YEL;
            EW_G: ewLight = LAMP_GRN;
            EW_Y: ewLight = LAMP_YEL;
            PED_WALK: walk = 1'b1;
            EMG_HOLD: emgClear = 1'b1;
            NIGHT_FLASH: begin
                nsLight = blink ? LAMP_YEL : LAMP_OFF;
                ewLight = blink ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Randomized-mode bench for traffic_light_sequencer against a phase/age model
// of the intersection built from the sequencing rules.
module tb_traffic_light_sequencer;

    localparam int G_LEN  = 8;
    localparam int Y_LEN  = 3;
    localparam int AR_LEN = 1;
    localparam int W_LEN  = 6;
    localparam int BL_LEN = 2;

    localparam int K_GRN = 0, K_YEL = 1, K_RED = 2, K_WALK = 3, K_NIGHT = 4, K_EMG = 5;
    localparam int RED = 4, YEL = 2, GRN = 1, OFF = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [2:0] ns, ew;
    logic       walk, emg;

    always #5 clk = ~clk;

    traffic_light_sequencer #(
        .GREEN_CYCLES  (G_LEN),
        .YELLOW_CYCLES (Y_LEN),
        .ALLRED_CYCLES (AR_LEN),
        .WALK_CYCLES   (W_LEN),
        .BLINK_CYCLES  (BL_LEN),
        .CNT_W         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .currentState (mode),
        .nsLight      (ns),
        .ewLight      (ew),
        .walk         (walk),
        .emgClear     (emg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", tag, actual, expected, $time);
    endtask

    // Model: phase kind, approach (0 NS / 1 EW) and cycles spent in the phase.
    int m_kind, m_appr, m_age, m_next_appr;
    bit m_served;

    function automatic int dur(input int k);
        case (k)
            K_GRN:   return G_LEN;
            K_YEL:   return Y_LEN;
            K_RED:   return AR_LEN;
            K_WALK:  return W_LEN;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input int md);
        int  nk, na;
        bit  expired;
        if (r) begin
            m_kind = K_RED; m_appr = 0; m_age = 0; m_next_appr = 0; m_served = 0;
            return;
        end
        nk = m_kind;
        na = m_appr;
        expired = (dur(m_kind) != 0) && (m_age + 1 >= dur(m_kind));
        case (m_kind)
            K_GRN: if (expired || md == 3) nk = K_YEL;
            K_YEL: if (expired) nk = K_RED;
            K_RED: if (expired) begin
                if (md == 3) nk = K_EMG;
                else if (md == 1) nk = K_NIGHT;
                else if (md == 2 && !m_served) nk = K_WALK;
                else begin nk = K_GRN; na = m_next_appr; end
            end
            K_WALK: if (expired) begin nk = K_RED; m_served = 1; end
            K_NIGHT: if (md != 1) nk = K_RED;
            K_EMG:   if (md != 3) nk = K_RED;
            default: nk = K_RED;
        endcase
        if (md != 2) m_served = 0;
        if (nk == K_YEL && m_kind != K_YEL) m_next_appr = 1 - m_appr;
        m_age  = (nk != m_kind) ? 0 : m_age + 1;
        m_kind = nk;
        m_appr = na;
    endtask

    function automatic int lamp_for(input int appr);
        bit on;
        case (m_kind)
            K_GRN: return (m_appr == appr) ? GRN : RED;
            K_YEL: return (m_appr == appr) ? YEL : RED;
            K_NIGHT: begin
                on = ((m_age / BL_LEN) % 2) == 0;
                if (appr == 0) return on ? YEL : OFF;
                return on ? RED : OFF;
            end
            default: return RED;
        endcase
    endfunction

    initial begin
        int hold;
        rst  = 1'b1;
        mode = 2'b00;
        hold = 0;
        model_step(1'b1, 0);
        @(posedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check_eq("ns_light", int'(ns), lamp_for(0));
            check_eq("ew_light", int'(ew), lamp_for(1));
            check_eq("walk", int'(walk), int'(m_kind == K_WALK));
            check_eq("emg_clear", int'(emg), int'(m_kind == K_EMG));
            check_eq("ns_onehot", int'($countones(ns) <= 1), 1);
            check_eq("ew_onehot", int'($countones(ew) <= 1), 1);
            check_eq("no_dual_go", int'((ns == 3'b001 || ns == 3'b010) &&
                                        (ew == 3'b001 || ew == 3'b010)), 0);

            if (cyc < 60) begin
                rst  = 1'b0;
                mode = 2'b00;
            end else begin
                rst = ($urandom_range(0, 249) == 0);
                if (hold == 0) begin
                    mode = 2'($urandom_range(0, 3));
                    hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                      : int'($urandom_range(5, 45));
                end
                hold--;
            end
            model_step(rst, int'(mode));
            @(posedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
